input_debouncer_2ch: RTL and testbench



---
 rtl/input_debouncer_2ch.sv | 144 ++++++++++++++
 tb/tb_input_debouncer_2ch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/input_debouncer_2ch.sv
// Two-channel button conditioner: per-channel synchronizer plus a 4-state debounce FSM.
// Produces clean levels for the gate stage and one-cycle rise/fall pulses.

module input_debouncer_channel #(
  parameter int CNT_MAX     = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // Any low sample during the wait is treated as bounce.
        if (!s) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  assign level_o = (state_q == IDLE_HIGH) || (state_q == WAIT_LOW);
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

module input_debouncer_2ch #(
  parameter int CNT_MAX     = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  input_debouncer_channel #(
    .CNT_MAX    (CNT_MAX),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ch_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (btn_a_raw),
    .level_o(a),
    .rise_o (a_rise),
    .fall_o (a_fall)
  );

  input_debouncer_channel #(
    .CNT_MAX    (CNT_MAX),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ch_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (btn_b_raw),
    .level_o(b),
    .rise_o (b_rise),
    .fall_o (b_fall)
  );

endmodule

// File: tb/tb_input_debouncer_2ch.sv
// Directed bench for input_debouncer_2ch with CNT_MAX=4, SYNC_STAGES=2.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_input_debouncer_2ch;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_a_raw, btn_b_raw;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  int n_vec = 0;
  int n_err = 0;

  input_debouncer_2ch #(
    .CNT_MAX    (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_a_raw(btn_a_raw),
    .btn_b_raw(btn_b_raw),
    .a        (a),
    .b        (b),
    .a_rise   (a_rise),
    .a_fall   (a_fall),
    .b_rise   (b_rise),
    .b_fall   (b_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reset with both raw inputs low and let the synchronizers flush.
  task automatic do_reset();
    rst_n     = 1'b0;
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
  endtask

  int rise_cnt;

  initial begin
    // Test 1: raw inputs high during reset.
    rst_n     = 1'b0;
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    #2;
    check("t1 async reset", {2'b0, a, b, a_rise, a_fall, b_rise, b_fall}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t1 in reset", {2'b0, a, b, a_rise, a_fall, b_rise, b_fall}, 8'h00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t1 a", {7'b0, a}, {7'b0, i >= 5});
      check("t1 a_rise", {7'b0, a_rise}, {7'b0, i == 5});
      check("t1 b/b_rise", {6'b0, b, b_rise}, {6'b0, i >= 5, i == 5});
      check("t1 falls", {6'b0, a_fall, b_fall}, 8'h00);
    end

    // Test 2: clean press and release on A; B stays idle.
    do_reset();
    btn_a_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t2 press a", {6'b0, a, a_rise}, {6'b0, i >= 5, i == 5});
      check("t2 press a_fall", {7'b0, a_fall}, 8'h00);
      check("t2 press b", {5'b0, b, b_rise, b_fall}, 8'h00);
    end
    btn_a_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t2 release a", {6'b0, a, a_fall}, {6'b0, i < 5, i == 5});
      check("t2 release a_rise", {7'b0, a_rise}, 8'h00);
      check("t2 release b", {5'b0, b, b_rise, b_fall}, 8'h00);
    end

    // Test 3: bouncing B never reaches CNT_MAX consecutive samples.
    begin
      logic [5:0] pat;
      pat = 6'b110110;
      for (int i = 5; i >= 0; i--) begin
        btn_b_raw = pat[i];
        cyc();
        check("t3 bounce b", {6'b0, b, b_rise}, 8'h00);
      end
    end
    btn_b_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t3 settle b", {5'b0, b, b_rise, b_fall}, 8'h00);
    end

    // Test 4: bounce 1,0 then settle high; latency counts from the final capture.
    btn_b_raw = 1'b1;
    cyc();
    check("t4 pre b", {6'b0, b, b_rise}, 8'h00);
    btn_b_raw = 1'b0;
    cyc();
    check("t4 pre b", {6'b0, b, b_rise}, 8'h00);
    btn_b_raw = 1'b1;
    rise_cnt  = 0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      rise_cnt += int'(b_rise);
      check("t4 b", {6'b0, b, b_rise}, {6'b0, i >= 5, i == 5});
    end
    check("t4 b_rise count", 8'(rise_cnt), 8'd1);

    // Test 5: simultaneous press on both channels.
    do_reset();
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t5 a/b", {6'b0, a, b}, (i >= 5) ? 8'h03 : 8'h00);
      check("t5 rises", {6'b0, a_rise, b_rise}, (i == 5) ? 8'h03 : 8'h00);
      if (i == 5)
        check("t5 gates and/or/xor", {5'b0, a & b, a | b, a ^ b}, 8'b110);
    end

    // Test 6: asynchronous reset while A is in WAIT_HIGH with count 2.
    do_reset();
    btn_a_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t6 wait a", {6'b0, a, a_rise}, 8'h00);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6 async a", {5'b0, a, a_rise, a_fall}, 8'h00);
    repeat (2) begin
      cyc();
      check("t6 held a", {5'b0, a, a_rise, a_fall}, 8'h00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t6 re a", {6'b0, a, a_rise}, {6'b0, i >= 5, i == 5});
      check("t6 re a_fall", {7'b0, a_fall}, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
